// File: rtl/ibex_register_file_ff_mp_if.sv
// External load port of the flip-flop register file: a valid/ready write
// channel used by a debug/test agent, plus the illegal-load error pulse.
interface ibex_register_file_ff_mp_if #(
   parameter int unsigned DataWidth = 32
);
   logic                 ext_valid_i;
   logic                 ext_ready_o;
   logic [4:0]           ext_addr_i;
   logic [DataWidth-1:0] ext_data_i;
   logic                 err_o;

   modport master (
      output ext_valid_i,
      output ext_addr_i,
      output ext_data_i,
      input  ext_ready_o,
      input  err_o
   );

   modport slave (
      input  ext_valid_i,
      input  ext_addr_i,
      input  ext_data_i,
      output ext_ready_o,
      output err_o
   );
endinterface

// File: rtl/ibex_register_file_ff_mp.sv
// Flip-flop register file: N combinational read ports, one core write port,
// an external load port, a dirty bitmap and a sequenced bulk-clear engine.
module ibex_register_file_ff_mp #(
   parameter bit                   RV32E       = 1'b0,
   parameter int unsigned          DataWidth   = 32,
   parameter int unsigned          NumRdPorts  = 2,
   parameter bit                   WriteBypass = 1'b0,
   parameter logic [DataWidth-1:0] WordZeroVal = '0,
   localparam int unsigned         NUM_WORDS   = RV32E ? 16 : 32
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumRdPorts*5-1:0]         raddr_i,
   output logic [NumRdPorts*DataWidth-1:0] rdata_o,
   input  logic [4:0]                      waddr_a_i,
   input  logic [DataWidth-1:0]            wdata_a_i,
   input  logic                            we_a_i,
   ibex_register_file_ff_mp_if.slave       ext,
   input  logic                            clr_req_i,
   output logic                            clr_busy_o,
   output logic                            clr_done_o,
   output logic [NUM_WORDS-1:0]            dirty_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

   clr_state_e           state_q, state_d;
   logic [4:0]           idx_q, idx_d;
   logic [DataWidth-1:0] mem_q [NUM_WORDS-1:1];
   logic [NUM_WORDS-1:1] dirty_q;
   logic                 err_p1;
   logic                 ext_ready;
   logic                 ext_fire;
   logic                 clearing;

   // Nonzero and backed by a flop.
   function automatic logic addr_in_range(input logic [4:0] a);
      return (a != 5'd0) && ({1'b0, a} < 6'(NUM_WORDS));
   endfunction

   assign clearing  = (state_q == CLEAR);
   assign ext_ready = (state_q == IDLE) && !we_a_i && !rst_i;
   assign ext_fire  = ext.ext_valid_i && ext_ready;

   assign ext.ext_ready_o = ext_ready;
   assign ext.err_o       = err_p1;
   assign clr_busy_o      = clearing;
   assign clr_done_o      = (state_q == DONE);
   assign dirty_o         = {dirty_q, 1'b0};

   // Clear sequencer: state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Clear sequencer: next state; the index stops at the last word, no wrap
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (clr_req_i) begin
               state_d = CLEAR;
               idx_d   = 5'd1;
            end
         end
         CLEAR: begin
            if (idx_q == 5'(NUM_WORDS - 1)) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Storage and dirty bits; core write beats clear beats external load
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 1; i < NUM_WORDS; i++) begin
            mem_q[i] <= WordZeroVal;
         end
         dirty_q <= '0;
      end else begin
         for (int i = 1; i < NUM_WORDS; i++) begin
            if (we_a_i && (waddr_a_i == 5'(i))) begin
               mem_q[i]   <= wdata_a_i;
               dirty_q[i] <= 1'b1;
            end else if (clearing && (idx_q == 5'(i))) begin
               mem_q[i]   <= WordZeroVal;
               dirty_q[i] <= 1'b0;
            end else if (ext_fire && (ext.ext_addr_i == 5'(i))) begin
               mem_q[i]   <= ext.ext_data_i;
               dirty_q[i] <= 1'b0;
            end
         end
      end
   end

   // Illegal external load: flagged one cycle after the accepted transfer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_p1 <= 1'b0;
      end else begin
         err_p1 <= ext_fire && !addr_in_range(ext.ext_addr_i);
      end
   end

   for (genvar p = 0; p < NumRdPorts; p++) begin : g_rd
      logic [4:0]           ra;
      logic [DataWidth-1:0] word;

      assign ra = raddr_i[5*p +: 5];

      // Out-of-range and x0 fall through to WordZeroVal
      always_comb begin
         word = WordZeroVal;
         for (int i = 1; i < NUM_WORDS; i++) begin
            if (ra == 5'(i)) begin
               word = mem_q[i];
            end
         end
         if (WriteBypass && we_a_i && (ra == waddr_a_i) && addr_in_range(waddr_a_i)) begin
            word = wdata_a_i;
         end
      end

      assign rdata_o[DataWidth*p +: DataWidth] = word;
   end

endmodule

// File: tb/tb_ibex_register_file_ff_mp.sv
// Directed bench for ibex_register_file_ff_mp: a 32-entry bypassing instance
// and a 16-entry (RV32E) instance sharing clock and reset.
module tb_ibex_register_file_ff_mp;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        we, clr_req, clr_busy, clr_done;
   logic [31:0] dirty;

   logic [9:0]  raddr_e;
   logic [63:0] rdata_e;
   logic [4:0]  waddr_e;
   logic [31:0] wdata_e;
   logic        we_e, clr_req_e, clr_busy_e, clr_done_e;
   logic [15:0] dirty_e;

   ibex_register_file_ff_mp_if #(.DataWidth(32)) bus ();
   ibex_register_file_ff_mp_if #(.DataWidth(32)) bus_e ();

   ibex_register_file_ff_mp #(
      .RV32E(1'b0), .DataWidth(32), .NumRdPorts(2), .WriteBypass(1'b1), .WordZeroVal('0)
   ) dut (
      .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata),
      .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we), .ext(bus),
      .clr_req_i(clr_req), .clr_busy_o(clr_busy), .clr_done_o(clr_done), .dirty_o(dirty)
   );

   ibex_register_file_ff_mp #(
      .RV32E(1'b1), .DataWidth(32), .NumRdPorts(2), .WriteBypass(1'b0), .WordZeroVal('0)
   ) dut_e (
      .clk_i(clk), .rst_i(rst), .raddr_i(raddr_e), .rdata_o(rdata_e),
      .waddr_a_i(waddr_e), .wdata_a_i(wdata_e), .we_a_i(we_e), .ext(bus_e),
      .clr_req_i(clr_req_e), .clr_busy_o(clr_busy_e), .clr_done_o(clr_done_e), .dirty_o(dirty_e)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Storage read through port 1 of the main instance
   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      raddr[9:5] = a;
      #1;
      chk(tag, rdata[63:32], exp);
   endtask

   initial begin
      int busy_cnt, rdy_cnt, done_cnt, wait_cnt;

      rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = 1'b0; clr_req = 1'b0;
      raddr_e = '0; waddr_e = '0; wdata_e = '0; we_e = 1'b0; clr_req_e = 1'b0;
      bus.ext_valid_i = 1'b0; bus.ext_addr_i = '0; bus.ext_data_i = '0;
      bus_e.ext_valid_i = 1'b0; bus_e.ext_addr_i = '0; bus_e.ext_data_i = '0;

      // Reset
      tick(); tick();
      chk1("ready_in_reset", bus.ext_ready_o, 1'b0);
      chk1("busy_in_reset", clr_busy, 1'b0);
      chk1("done_in_reset", clr_done, 1'b0);
      chk1("err_in_reset", bus.err_o, 1'b0);
      rst = 1'b0;
      tick();
      chk1("ready_after_reset", bus.ext_ready_o, 1'b1);
      chk("dirty_after_reset", dirty, 32'h0);
      for (int a = 0; a < 32; a++) begin
         raddr = {a[4:0], a[4:0]};
         #1;
         chk("reset_rd_p0", rdata[31:0], 32'h0);
         chk("reset_rd_p1", rdata[63:32], 32'h0);
      end

      // Core write with same-cycle bypass
      tick();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd6, 5'd5};
      #1;
      chk("bypass_p0", rdata[31:0], 32'hDEADBEEF);
      chk("no_bypass_p1", rdata[63:32], 32'h0);
      chk("dirty_before_edge", dirty, 32'h0);
      tick();
      we = 1'b0;
      #1;
      chk("dirty_x5", dirty, 32'h0000_0020);
      rd("rd_x5", 5'd5, 32'hDEADBEEF);

      // External load stalled by two core writes to the same register
      tick();
      bus.ext_valid_i = 1'b1; bus.ext_addr_i = 5'd7; bus.ext_data_i = 32'h1234;
      we = 1'b1; waddr = 5'd7; wdata = 32'h77;
      #1;
      chk1("ready_stall_c1", bus.ext_ready_o, 1'b0);
      tick();
      chk1("ready_stall_c2", bus.ext_ready_o, 1'b0);
      chk("dirty_core_x7", dirty, 32'h0000_00A0);
      tick();
      we = 1'b0;
      #1;
      chk1("ready_c3", bus.ext_ready_o, 1'b1);
      tick();
      bus.ext_valid_i = 1'b0;
      #1;
      chk("dirty_after_ext", dirty, 32'h0000_0020);
      chk1("err_legal_load", bus.err_o, 1'b0);
      rd("rd_x7_ext", 5'd7, 32'h1234);

      // Illegal external loads
      tick();
      bus.ext_valid_i = 1'b1; bus.ext_addr_i = 5'd0; bus.ext_data_i = 32'hFFFF;
      #1;
      chk1("ready_addr0", bus.ext_ready_o, 1'b1);
      tick();
      bus.ext_valid_i = 1'b0;
      #1;
      chk1("err_addr0", bus.err_o, 1'b1);
      chk1("ready_err", bus.ext_ready_o, 1'b1);
      tick();
      chk1("err_addr0_one_cycle", bus.err_o, 1'b0);
      chk("dirty_err", dirty, 32'h0000_0020);
      rd("rd_x0", 5'd0, 32'h0);

      bus_e.ext_valid_i = 1'b1; bus_e.ext_addr_i = 5'd20; bus_e.ext_data_i = 32'hABCD;
      we_e = 1'b1; waddr_e = 5'd20; wdata_e = 32'h5;
      tick();
      we_e = 1'b0;
      #1;
      chk1("ready_e_core_blocked", bus_e.ext_ready_o, 1'b1);
      chk1("err_e_none_yet", bus_e.err_o, 1'b0);
      tick();
      bus_e.ext_valid_i = 1'b0;
      #1;
      chk1("err_e_addr20", bus_e.err_o, 1'b1);
      chk1("ready_e", bus_e.ext_ready_o, 1'b1);
      chk("dirty_e_dropped", {16'h0, dirty_e}, 32'h0);
      raddr_e = {5'd20, 5'd20};
      #1;
      chk("rd_e_x20", rdata_e[31:0], 32'h0);
      tick();
      chk1("err_e_one_cycle", bus_e.err_o, 1'b0);

      // Preload every register, then bulk clear
      for (int i = 1; i < 32; i++) begin
         bus.ext_valid_i = 1'b1; bus.ext_addr_i = 5'(i); bus.ext_data_i = 32'(i);
         tick();
      end
      bus.ext_valid_i = 1'b0;
      #1;
      rd("preload_x1", 5'd1, 32'd1);
      rd("preload_x5", 5'd5, 32'd5);
      rd("preload_x31", 5'd31, 32'd31);
      chk("dirty_preload", dirty, 32'h0);
      clr_req = 1'b1;
      #1;
      chk1("busy_before_clear", clr_busy, 1'b0);
      tick();
      clr_req = 1'b0;
      busy_cnt = 0; rdy_cnt = 0;
      for (int c = 0; c < 40 && !clr_done; c++) begin
         if (clr_busy) busy_cnt++;
         if (bus.ext_ready_o) rdy_cnt++;
         tick();
      end
      chk("clear_busy_cycles", busy_cnt, 32'd31);
      chk("clear_ready_cycles", rdy_cnt, 32'd0);
      chk1("clear_done", clr_done, 1'b1);
      chk1("busy_in_done", clr_busy, 1'b0);
      chk1("ready_in_done", bus.ext_ready_o, 1'b0);
      tick();
      chk1("done_one_cycle", clr_done, 1'b0);
      chk1("ready_after_clear", bus.ext_ready_o, 1'b1);
      for (int a = 1; a < 32; a++) begin
         rd("cleared_reg", a[4:0], 32'h0);
      end

      // Core writes racing the clear index
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick(); tick();
      we = 1'b1; waddr = 5'd3; wdata = 32'hA5;
      tick();
      we = 1'b0;
      tick();
      we = 1'b1; waddr = 5'd2; wdata = 32'h22;
      tick();
      we = 1'b0;
      wait_cnt = 0;
      while (!clr_done && wait_cnt < 40) begin
         tick();
         wait_cnt++;
      end
      chk1("race_clear_done", clr_done, 1'b1);
      tick();
      rd("race_x3", 5'd3, 32'hA5);
      rd("race_x2", 5'd2, 32'h22);
      rd("race_x4", 5'd4, 32'h0);
      chk("race_dirty", dirty, 32'h0000_000C);

      // Reset in the middle of a clear
      we = 1'b1; waddr = 5'd4; wdata = 32'h44;
      tick();
      we = 1'b0; clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick(); tick();
      chk1("busy_before_rst", clr_busy, 1'b1);
      rst = 1'b1;
      #1;
      chk1("ready_rst_mid", bus.ext_ready_o, 1'b0);
      tick();
      chk1("busy_after_rst", clr_busy, 1'b0);
      chk1("done_after_rst", clr_done, 1'b0);
      rst = 1'b0;
      done_cnt = 0; busy_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (clr_done) done_cnt++;
         if (clr_busy) busy_cnt++;
         tick();
      end
      chk("rst_no_done", done_cnt, 32'd0);
      chk("rst_no_busy", busy_cnt, 32'd0);
      chk1("rst_ready", bus.ext_ready_o, 1'b1);
      chk("rst_dirty", dirty, 32'h0);
      rd("rst_x4", 5'd4, 32'h0);
      rd("rst_x3", 5'd3, 32'h0);
      rd("rst_x2", 5'd2, 32'h0);

      // RV32E clear length
      tick();
      clr_req_e = 1'b1;
      tick();
      clr_req_e = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 40 && !clr_done_e; c++) begin
         if (clr_busy_e) busy_cnt++;
         tick();
      end
      chk("e_clear_busy_cycles", busy_cnt, 32'd15);
      chk1("e_clear_done", clr_done_e, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ibex_register_file_ff_mp.md
Name: ibex_register_file_ff_mp

Overview:
Flip-flop register file with a configurable number of read ports, one core write port, and an external load port using a valid/ready handshake. It adds an optional write-to-read bypass, a per-register dirty bitmap, and a sequenced bulk-clear engine. It sits in the ID stage for FPGA/Verilator targets. A debug/test agent uses the load port to preload or scrub architectural state.

Parameters:
RV32E, 0, 1 selects 16 registers, 0 selects 32; NUM_WORDS = RV32E ? 16 : 32
DataWidth, 32, register width in bits
NumRdPorts, 2, number of independent read ports (1..4)
WriteBypass, 0, 1 forwards the same-cycle core write data to matching read ports
WordZeroVal, '0, value of x0 and the reset/clear value of every register

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
raddr_i  in  NumRdPorts*5  read addresses; port p uses bits [5p+4:5p]
rdata_o  out  NumRdPorts*DataWidth  read data; port p uses bits [DataWidth*(p+1)-1:DataWidth*p]
waddr_a_i  in  5  core write address
wdata_a_i  in  DataWidth  core write data
we_a_i  in  1  core write enable
ext_valid_i  in  1  external load request valid
ext_ready_o  out  1  external load ready
ext_addr_i  in  5  external load address
ext_data_i  in  DataWidth  external load data
clr_req_i  in  1  start a bulk clear
clr_busy_o  out  1  bulk clear in progress
clr_done_o  out  1  one-cycle pulse when the clear completes
dirty_o  out  NUM_WORDS  bit i is set while register i holds core-written data
err_o  out  1  one-cycle pulse for an illegal external load

Behaviour:
- Clocking: one clock, clk_i. rst_i is synchronous and active-high; all state updates on the posedge of clk_i.
- Reset state: registers 1..NUM_WORDS-1 = WordZeroVal; dirty_o = 0; FSM = IDLE; clr_busy_o = 0; clr_done_o = 0; err_o = 0.
- While rst_i = 1, ext_ready_o = 0.
- Storage:
  - x0 has no flop and always reads WordZeroVal.
  - In RV32E mode, addresses >= 16 read WordZeroVal.
  - Core writes to address 0 or to an address >= NUM_WORDS are silently dropped.
- Read ports: combinational, zero latency, fully independent of each other.
- Bypass (WriteBypass = 1):
  - Condition: we_a_i = 1, raddr == waddr_a_i, and the address is in range and nonzero.
  - Then rdata = wdata_a_i in the same cycle.
  - Neither external loads nor clear writes are bypassed.
- Core write: the register updates at the next edge. Core writes are accepted in every FSM state.
- External load handshake:
  - ext_ready_o = (FSM == IDLE) & ~we_a_i & ~rst_i, purely combinational. It does not depend on ext_valid_i.
  - Transfer occurs when ext_valid_i & ext_ready_o. The register updates at the next edge.
  - ext_valid_i may be held across stall cycles. The source must keep ext_addr_i and ext_data_i stable until the transfer.
  - A transfer to address 0 or to an address >= NUM_WORDS writes nothing and raises err_o for exactly one cycle on the following cycle.
- Dirty bitmap:
  - A core write to register i sets dirty[i].
  - An external load or a clear of register i resets dirty[i].
  - dirty[0] is always 0.
- Write priority per register per cycle: core write > clear > external load. An external load cannot coincide with a core write or with CLEAR, because ready is low in both cases.
- FSM:
  - IDLE -> CLEAR when clr_req_i = 1. The index counter loads 1.
  - CLEAR: each cycle, register[idx] = WordZeroVal, dirty[idx] = 0, idx += 1. clr_busy_o = 1.
  - CLEAR -> DONE after the cycle with idx = NUM_WORDS-1. CLEAR therefore lasts exactly NUM_WORDS-1 cycles.
  - DONE: clr_done_o = 1 and clr_busy_o = 0 for one cycle, then -> IDLE.
  - clr_req_i is ignored outside IDLE. A request held high through DONE restarts the clear on the cycle after the return to IDLE.
  - If a core write hits register idx in the same cycle that register is being cleared, the core value and dirty = 1 win. That register is not revisited.
  - Core writes to an already-cleared index persist.
- Reset mid-clear: the FSM returns to IDLE, all state takes its reset values, and no clr_done_o pulse is produced.
- Width rules: the index counter is 5 bits. With RV32E = 1 only bits [3:0] are used and idx never exceeds NUM_WORDS-1 (no wrap).

Test Plan:
- Reset, then read all addresses on every port -> every rdata = 0x0, dirty_o = 0, ext_ready_o = 1 one cycle after reset deasserts.
- Core write x5 = 0xDEADBEEF with WriteBypass = 1 and raddr port0 = 5 in the same cycle -> rdata port0 = 0xDEADBEEF that cycle, dirty[5] = 1 next cycle.
- ext_valid_i = 1, ext_addr_i = 7, ext_data_i = 0x1234 while we_a_i = 1 for 2 cycles -> ready low for 2 cycles, transfer on cycle 3, x7 = 0x1234, dirty[7] = 0.
- External load to address 0 (and to address 20 with RV32E = 1) -> no register change, err_o pulses for one cycle, ext_ready_o stays 1.
- Preload x1..x31 = i, then clr_req_i pulse -> clr_busy_o high for 31 cycles, clr_done_o pulses on cycle 32, all registers 0, ext_ready_o = 0 throughout the clear.
- Core write x3 = 0xA5 on the cycle idx = 3 during a clear, then assert rst_i mid-clear in a second run -> x3 = 0xA5 with dirty[3] = 1 after the first clear; after the reset, FSM is IDLE, no done pulse, all registers 0.
